// File: rtl/bcd_score_counter_pkg.sv
// Shared definitions for the two-digit BCD score counter.
package bcd_score_counter_pkg;

  localparam logic [3:0] BCD_MIN = 4'd0;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Two-digit BCD value, tens in the upper nibble.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Action selected from the three press pulses in one cycle.
  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_INC  = 2'd1,
    ACT_DEC  = 2'd2,
    ACT_CLR  = 2'd3
  } act_e;

  // Stability counter width: $clog2 of the debounce length, never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 3) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/bcd_score_counter_button_conditioner.sv
// Synchroniser, debouncer and rising-edge press pulse for one raw button.
module button_conditioner
  import bcd_score_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] stable_cnt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync[1] == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      level      <= sync[1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

  // One-cycle registered pulse on the debounced rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Two-digit BCD up/down score counter driven by three debounced push-buttons.
module bcd_score_counter
  import bcd_score_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          WRAP            = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clear,
  output logic [3:0] Disp_1,
  output logic [3:0] Disp_2,
  output logic       rollover
);

  logic  press_up;
  logic  press_down;
  logic  press_clear;
  act_e  act;
  bcd2_t count_q;
  bcd2_t count_nxt;
  logic  wrap_hit;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .press (press_up)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .press (press_down)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .press (press_clear)
  );

  // Clear wins; simultaneous up and down cancel each other.
  always_comb begin
    act = ACT_NONE;
    if (press_clear) begin
      act = ACT_CLR;
    end else if (press_up && !press_down) begin
      act = ACT_INC;
    end else if (press_down && !press_up) begin
      act = ACT_DEC;
    end
  end

  // BCD increment/decrement with carry/borrow, wrap or saturate at the ends.
  always_comb begin
    count_nxt = count_q;
    wrap_hit  = 1'b0;
    case (act)
      ACT_CLR: begin
        count_nxt = '{tens: BCD_MIN, ones: BCD_MIN};
      end
      ACT_INC: begin
        if (count_q.ones != BCD_MAX) begin
          count_nxt.ones = count_q.ones + 4'd1;
        end else if (count_q.tens != BCD_MAX) begin
          count_nxt.ones = BCD_MIN;
          count_nxt.tens = count_q.tens + 4'd1;
        end else if (WRAP) begin
          count_nxt = '{tens: BCD_MIN, ones: BCD_MIN};
          wrap_hit  = 1'b1;
        end
      end
      ACT_DEC: begin
        if (count_q.ones != BCD_MIN) begin
          count_nxt.ones = count_q.ones - 4'd1;
        end else if (count_q.tens != BCD_MIN) begin
          count_nxt.ones = BCD_MAX;
          count_nxt.tens = count_q.tens - 4'd1;
        end else if (WRAP) begin
          count_nxt = '{tens: BCD_MAX, ones: BCD_MAX};
          wrap_hit  = 1'b1;
        end
      end
      default: begin
        count_nxt = count_q;
      end
    endcase
  end

  // Registered count and rollover pulse aligned with the wrapped value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '{tens: BCD_MIN, ones: BCD_MIN};
      rollover <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      rollover <= wrap_hit;
    end
  end

  assign Disp_1 = count_q.ones;
  assign Disp_2 = count_q.tens;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench: one wrapping and one saturating counter share the same buttons.
module tb_bcd_score_counter;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       btn_clear;
  logic [3:0] w_ones, w_tens, s_ones, s_tens;
  logic       w_roll, s_roll;

  int compared;
  int mismatched;

  bcd_score_counter #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_clear (btn_clear),
    .Disp_1    (w_ones),
    .Disp_2    (w_tens),
    .rollover  (w_roll)
  );

  bcd_score_counter #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b0)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_clear (btn_clear),
    .Disp_1    (s_ones),
    .Disp_2    (s_tens),
    .rollover  (s_roll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       up;
    logic       down;
    logic       clr;
    logic [7:0] exp_w;
    logic [7:0] exp_s;
    int         roll_w;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the given buttons for 12 cycles, release for 12, counting rollover cycles.
  task automatic press(input logic u, input logic d, input logic c,
                       output int rw, output int rs);
    rw = 0;
    rs = 0;
    btn_up    = u;
    btn_down  = d;
    btn_clear = c;
    repeat (12) begin
      @(posedge clk); #1;
      if (w_roll === 1'b1) rw++;
      if (s_roll === 1'b1) rs++;
    end
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_clear = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (w_roll === 1'b1) rw++;
      if (s_roll === 1'b1) rs++;
    end
  endtask

  task automatic press_check(input string name, input logic u, input logic d, input logic c,
                             input logic [7:0] ew, input logic [7:0] es, input int erw);
    int rw, rs;
    press(u, d, c, rw, rs);
    check($sformatf("%s_wrap_val", name), {8'h0, w_tens, w_ones}, {8'h0, ew});
    check($sformatf("%s_sat_val", name),  {8'h0, s_tens, s_ones}, {8'h0, es});
    check($sformatf("%s_wrap_roll", name), 16'(rw), 16'(erw));
    check($sformatf("%s_sat_roll", name),  16'(rs), 16'd0);
  endtask

  task automatic press_n(input int n);
    int rw, rs;
    for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0, rw, rs);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    btn_clear  = 1'b0;
    rst_n      = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h99, 8'h00, 1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h98, 8'h00, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h99, 8'h01, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h99, 8'h01, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_wrap", {7'h0, w_roll, w_tens, w_ones}, 16'h0);
    check("reset_sat",  {7'h0, s_roll, s_tens, s_ones}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean press: count changes exactly on the 8th edge, once despite the hold
    repeat (2) @(posedge clk);
    @(negedge clk);
    btn_up = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 7) check("lat_e7", {8'h0, w_tens, w_ones}, 16'h00);
      if (e == 8) check("lat_e8", {8'h0, w_tens, w_ones}, 16'h01);
    end
    check("hold_once", {8'h0, w_tens, w_ones, s_tens, s_ones}, 16'h0101);
    btn_up = 1'b0;
    repeat (12) @(posedge clk);

    // Bounce shorter than the debounce window is ignored
    #1;
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      repeat (2) @(posedge clk);
      #1;
    end
    btn_up = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("glitch", {8'h0, w_tens, w_ones, s_tens, s_ones}, 16'h0101);

    // Table-driven presses from 00
    press_check("clr0", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0);
    for (int i = 0; i < 14; i++) begin
      press_check($sformatf("vec%0d", i), vecs[i].up, vecs[i].down, vecs[i].clr,
                  vecs[i].exp_w, vecs[i].exp_s, vecs[i].roll_w);
    end

    // 99 increments, then the wrapping/saturating one with exact rollover timing
    press_n(99);
    check("at99", {w_tens, w_ones, s_tens, s_ones}, 16'h9999);
    @(negedge clk);
    btn_up = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      if (e == 7) check("wrap_e7", {7'h0, w_roll, w_tens, w_ones}, 16'h099);
      if (e == 8) check("wrap_e8", {7'h0, w_roll, w_tens, w_ones}, 16'h100);
      if (e == 8) check("sat_e8", {7'h0, s_roll, s_tens, s_ones}, 16'h099);
      if (e == 9) check("wrap_e9", {7'h0, w_roll, w_tens, w_ones}, 16'h000);
    end
    btn_up = 1'b0;
    repeat (12) @(posedge clk);
    press_check("down_after_wrap", 1'b0, 1'b1, 1'b0, 8'h99, 8'h98, 1);
    press_check("clr1", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0);
    press_check("down_at00", 1'b0, 1'b1, 1'b0, 8'h99, 8'h00, 1);

    // Count 37: up+down cancel, up+clear clears
    press_check("clr2", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0);
    press_n(37);
    check("at37", {w_tens, w_ones, s_tens, s_ones}, 16'h3737);
    press_check("cancel37", 1'b1, 1'b1, 1'b0, 8'h37, 8'h37, 0);
    press_check("upclr37", 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 0);

    // Count 12, reset mid-debounce with the button held through release
    press_n(12);
    check("at12", {w_tens, w_ones, s_tens, s_ones}, 16'h1212);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", {7'h0, w_roll, w_tens, w_ones, s_tens, s_ones}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 7) check("rel_e7", {8'h0, w_tens, w_ones}, 16'h00);
      if (e == 8) check("rel_e8", {w_tens, w_ones, s_tens, s_ones}, 16'h0101);
    end
    btn_up = 1'b0;
    repeat (12) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
